// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_pkg
// Purpose  : Shared OTTER core definitions. These are the PC-source select
//            encodings produced by the control-unit decoder, the fetch FSM
//            state encoding, and the canonical NOP instruction.
// Revision : 1.0  initial release
// ============================================================================
package otter_pkg;

    // The decoder drives these codes onto PC_SOURCE. Codes 6..15 are unused
    // and are treated as "no redirect" by the fetch stage.
    typedef enum logic [3:0] {
        PC_PLUS4  = 4'd0,
        PC_JALR   = 4'd1,
        PC_BRANCH = 4'd2,
        PC_JAL    = 4'd3,
        PC_MTVEC  = 4'd4,
        PC_MEPC   = 4'd5
    } pcsrc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/otter_pc_mux.sv
`default_nettype none
// ============================================================================
// Module   : otter_pc_mux
// Purpose  : Combinational next-PC selector. It picks the redirect target
//            selected by the decoder and flags whether the code requests a
//            redirect at all.
// Ports    : i_pc_source      decoder PC-source code
//            i_pc_plus4       sequential PC
//            i_jalr_tgt, i_branch_tgt, i_jal_tgt, i_mtvec, i_mepc  targets
//            o_next_pc        selected target, bits[1:0] forced to 00
//            o_redirect_sel   code is one of the redirecting sources (1..5)
// Revision : 1.0  initial release
// ============================================================================
module otter_pc_mux (
    input  logic [3:0]  i_pc_source,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_jalr_tgt,
    input  logic [31:0] i_branch_tgt,
    input  logic [31:0] i_jal_tgt,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic [31:0] o_next_pc,
    output logic        o_redirect_sel
);
    import otter_pkg::*;

    logic [31:0] w_sel_pc;

    always_comb begin
        w_sel_pc       = i_pc_plus4;
        o_redirect_sel = 1'b1;
        case (i_pc_source)
            PC_JALR:   w_sel_pc = i_jalr_tgt;
            PC_BRANCH: w_sel_pc = i_branch_tgt;
            PC_JAL:    w_sel_pc = i_jal_tgt;
            PC_MTVEC:  w_sel_pc = i_mtvec;
            PC_MEPC:   w_sel_pc = i_mepc;
            // PC_PLUS4 and the unused codes 6..15 keep sequential flow
            default:   o_redirect_sel = 1'b0;
        endcase
    end

    assign o_next_pc = word_align(w_sel_pc);

endmodule
`default_nettype wire

// File: rtl/otter_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : otter_fetch_stage
// Purpose  : OTTER pipeline fetch stage. It owns the PC, runs a req/ack
//            instruction-memory handshake with one request outstanding, and
//            loads the IF/ID register. It supports stall, redirect/flush, and
//            a one-entry skid buffer that keeps a word fetched during a stall.
// Ports    : clk, rst (sync, active-high)
//            pc_source/ex_valid + jalr/branch/jal/mtvec/mepc targets
//            stall            hold IF/ID and PC this cycle
//            imem_req/addr    request out; imem_ack/rdata response in
//            if_id_valid/pc/pc4/ir   IF/ID pipeline register
// Revision : 1.0  initial release
// ============================================================================
module otter_fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = otter_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pc_source,
    input  logic        ex_valid,
    input  logic [31:0] jalr_tgt,
    input  logic [31:0] branch_tgt,
    input  logic [31:0] jal_tgt,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_ir
);
    import otter_pkg::fetch_state_t;
    import otter_pkg::IDLE;
    import otter_pkg::REQ;
    import otter_pkg::HOLD;
    import otter_pkg::DRAIN;

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_imem_req;
    logic [31:0]  r_imem_addr;
    logic         r_skid_valid;
    logic [31:0]  r_skid_data;
    logic [31:0]  r_skid_pc;
    logic         r_if_id_valid;
    logic [31:0]  r_if_id_pc;
    logic [31:0]  r_if_id_pc4;
    logic [31:0]  r_if_id_ir;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic         w_redirect_sel;
    logic         w_redirect;

    assign w_pc_plus4 = r_pc + 32'd4;

    otter_pc_mux u_pc_mux (
        .i_pc_source    (pc_source),
        .i_pc_plus4     (w_pc_plus4),
        .i_jalr_tgt     (jalr_tgt),
        .i_branch_tgt   (branch_tgt),
        .i_jal_tgt      (jal_tgt),
        .i_mtvec        (mtvec),
        .i_mepc         (mepc),
        .o_next_pc      (w_target),
        .o_redirect_sel (w_redirect_sel)
    );

    // A bubble in EX must never steer the PC.
    assign w_redirect = ex_valid & w_redirect_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_VEC;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_VEC;
            r_skid_valid  <= 1'b0;
            r_skid_data   <= NOP_INSTR;
            r_skid_pc     <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= 32'd0;
            r_if_id_pc4   <= 32'd4;
            r_if_id_ir    <= NOP_INSTR;
        end else begin
            // Redirect overrides stall in every state. The state-specific
            // handshake bookkeeping is done in the case below.
            if (w_redirect) begin
                r_if_id_valid <= 1'b0;
                r_if_id_ir    <= NOP_INSTR;
                r_skid_valid  <= 1'b0;
                r_pc          <= w_target;
            end

            case (r_state)
                IDLE: begin
                    r_state     <= REQ;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_redirect ? w_target : r_pc;
                end

                REQ: begin
                    if (w_redirect) begin
                        // Without an ACK, the in-flight request must still
                        // finish on its old address, so drain it first.
                        if (imem_ack) begin
                            r_imem_addr <= w_target;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_pc        <= w_pc_plus4;
                        r_imem_addr <= w_pc_plus4;
                        if (!stall) begin
                            r_if_id_valid <= 1'b1;
                            r_if_id_pc    <= r_pc;
                            r_if_id_pc4   <= w_pc_plus4;
                            r_if_id_ir    <= imem_rdata;
                        end else begin
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= imem_rdata;
                            r_skid_pc    <= r_pc;
                            r_state      <= HOLD;
                            r_imem_req   <= 1'b0;
                        end
                    end
                end

                HOLD: begin
                    if (w_redirect) begin
                        r_state     <= REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_target;
                    end else if (!stall) begin
                        if (r_skid_valid) begin
                            r_if_id_valid <= 1'b1;
                            r_if_id_pc    <= r_skid_pc;
                            r_if_id_pc4   <= r_skid_pc + 32'd4;
                            r_if_id_ir    <= r_skid_data;
                        end
                        r_skid_valid <= 1'b0;
                        r_state      <= REQ;
                        r_imem_req   <= 1'b1;
                        r_imem_addr  <= r_pc;
                    end
                end

                DRAIN: begin
                    // The squashed request's data is dropped; the PC already
                    // holds the latest target.
                    if (imem_ack) begin
                        r_state     <= REQ;
                        r_imem_addr <= w_redirect ? w_target : r_pc;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_ir    = r_if_id_ir;

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_otter_fetch_stage
// Purpose  : Directed self-checking bench for otter_fetch_stage. A simple
//            memory answers requests; fetched words are queued as expected
//            IF/ID contents and compared when the IF/ID register loads.
// Revision : 1.0  initial release
// ============================================================================
module tb_otter_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pc_source;
    logic        ex_valid;
    logic [31:0] jalr_tgt, branch_tgt, jal_tgt, mtvec, mepc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc, if_id_pc4, if_id_ir;
    logic        ack_en;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;
    exp_t sb_q[$];

    // Memory contents: address 16 holds 0x00500093, everything else distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + ((a - 32'd16) << 7);
    endfunction

    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem_word(imem_addr);

    always #5 clk = ~clk;

    otter_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_source   (pc_source),
        .ex_valid    (ex_valid),
        .jalr_tgt    (jalr_tgt),
        .branch_tgt  (branch_tgt),
        .jal_tgt     (jal_tgt),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_ir    (if_id_ir)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Checks the request currently presented, optionally queues the word
    // the memory returns as an expected IF/ID load, then clocks once.
    task automatic fetch(input string tag, input logic [31:0] a, input bit deliver);
        chk({tag, "_req"},  {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, a);
        if (deliver && ack_en) sb_q.push_back(exp_t'{pc: a, ir: mem_word(a)});
        cyc();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_ir"},    if_id_ir, 32'h13);
        chk({tag, "_pc"},    if_id_pc, 32'h0);
        chk({tag, "_pc4"},   if_id_pc4, 32'h4);
    endtask

    // Scoreboard monitor: every new IF/ID load must match the queue head.
    bit          prev_v  = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    always @(negedge clk) begin
        if (rst || !if_id_valid) begin
            prev_v = 1'b0;
        end else if (!prev_v || if_id_pc !== prev_pc) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected_load observed_pc=%h expected=none", if_id_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_pc",  if_id_pc,  e.pc);
                chk("sb_pc4", if_id_pc4, e.pc + 32'd4);
                chk("sb_ir",  if_id_ir,  e.ir);
            end
            prev_v  = 1'b1;
            prev_pc = if_id_pc;
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; pc_source = 4'd0; stall = 1'b0; ack_en = 1'b1;
        jalr_tgt = 32'h0000_0A00; branch_tgt = 32'h0; jal_tgt = 32'h0;
        mtvec = 32'h0; mepc = 32'h0;
        cyc();
        cyc();
        chk_reset("rst0");
        rst = 1'b0;
        cyc();                                   // IDLE -> REQ

        // 1: sequential fetch with same-cycle ACK
        for (int i = 0; i < 4; i++) fetch("t1", 32'(4 * i), 1'b1);
        chk("t1_valid", {31'd0, if_id_valid}, 32'd1);
        chk("t1_pc_lag", if_id_pc, 32'd12);

        // 2: stall while the word at 16 arrives -> skid, released later
        stall = 1'b1;
        fetch("t2_cap", 32'd16, 1'b1);
        chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
        chk("t2_hold_pc0", if_id_pc, 32'd12);
        cyc();
        chk("t2_hold_pc1", if_id_pc, 32'd12);
        chk("t2_hold_ir1", if_id_ir, mem_word(32'd12));
        cyc();
        chk("t2_hold_pc2", if_id_pc, 32'd12);
        stall = 1'b0;
        cyc();
        chk("t2_rel_pc", if_id_pc, 32'd16);
        chk("t2_rel_ir", if_id_ir, 32'h0050_0093);

        // 3: JAL redirect with same-cycle ACK
        ex_valid = 1'b1; pc_source = 4'd3; jal_tgt = 32'h100;
        fetch("t3", 32'd20, 1'b0);
        ex_valid = 1'b0; pc_source = 4'd0;
        chk("t3_valid", {31'd0, if_id_valid}, 32'd0);
        chk("t3_ir", if_id_ir, 32'h13);
        fetch("t3_tgt", 32'h100, 1'b1);

        // 4: branch redirect while the ACK is 2 cycles late
        ack_en = 1'b0; ex_valid = 1'b1; pc_source = 4'd2; branch_tgt = 32'h200;
        fetch("t4_redir", 32'h104, 1'b0);
        ex_valid = 1'b0; pc_source = 4'd0;
        chk("t4_flush_valid", {31'd0, if_id_valid}, 32'd0);
        fetch("t4_drain0", 32'h104, 1'b0);
        ack_en = 1'b1;
        fetch("t4_drain1", 32'h104, 1'b0);
        chk("t4_no_stale", {31'd0, if_id_valid}, 32'd0);
        fetch("t4_tgt", 32'h200, 1'b1);

        // 5: redirect + stall with a full skid: flush wins
        stall = 1'b1;
        fetch("t5_cap", 32'h204, 1'b0);
        chk("t5_hold_pc", if_id_pc, 32'h200);
        ex_valid = 1'b1; pc_source = 4'd4; mtvec = 32'h80;
        cyc();
        ex_valid = 1'b0; pc_source = 4'd0; stall = 1'b0;
        chk("t5_valid", {31'd0, if_id_valid}, 32'd0);
        chk("t5_ir", if_id_ir, 32'h13);
        fetch("t5_tgt", 32'h80, 1'b1);

        // 6: unused codes do not redirect; reset in DRAIN
        ex_valid = 1'b1; pc_source = 4'd7; jal_tgt = 32'h500; mepc = 32'h600;
        fetch("t6_code7", 32'h84, 1'b1);
        pc_source = 4'd15;
        fetch("t6_code15", 32'h88, 1'b1);
        ack_en = 1'b0; pc_source = 4'd5; mepc = 32'h300;
        fetch("t6_redir", 32'h8C, 1'b0);
        ex_valid = 1'b0; pc_source = 4'd0;
        chk("t6_drain_addr", imem_addr, 32'h8C);
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        rst = 1'b1;
        cyc();
        chk_reset("t6_rst");
        rst = 1'b0; ack_en = 1'b1;
        cyc();
        fetch("t6_re0", 32'h0, 1'b1);
        fetch("t6_re4", 32'h4, 1'b1);
        ack_en = 1'b0;
        cyc();
        chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
